// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage access sequencer.
package MemAccessType;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RESP,
    MEM_HOLD
  } memState;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned CNT_W            = 16;
  localparam int unsigned BYTE_OFFSET_BITS = $clog2(XLEN_DEFAULT / 8);

  function automatic int unsigned byte_offset_bits(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Saturating 16-bit response-wait counter with a timeout compare.
module mem_timeout_counter
  import MemAccessType::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: issues one data-bus request per M-stage access,
// stalls the pipeline while it is outstanding and reports faults.
module mem_access_unit
  import MemAccessType::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidInstruction_M,
  input  logic              MemEn_M,
  input  logic              MemWriteEn_M,
  input  logic [XLEN-1:0]   ComputeResult_M,
  input  logic [XLEN-1:0]   MemWriteData_M,
  input  logic [XLEN/8-1:0] MemWriteByteEn_M,
  input  logic              Flush_M,
  input  logic              StallExt_W,
  output logic              DBusReq,
  output logic              DBusWe,
  output logic [XLEN-1:0]   DBusAdr,
  output logic [XLEN-1:0]   DBusWData,
  output logic [XLEN/8-1:0] DBusByteEn,
  input  logic              DBusGnt,
  input  logic              DBusRValid,
  input  logic [XLEN-1:0]   DBusRData,
  input  logic              DBusErr,
  output logic [XLEN-1:0]   MemReadData_M,
  output logic              MemDataValid_M,
  output logic              AccessFault_M,
  output logic              Stall_M
);

  localparam int unsigned    OFF      = byte_offset_bits(XLEN);
  localparam logic [XLEN-1:0] ADR_MASK = ~XLEN'((1 << OFF) - 1);

  memState             state_q, state_d;
  logic                start;
  logic                discard_q, discard_d;
  logic                we_q;
  logic [XLEN-1:0]     adr_q, wdata_q, rdata_q, rdata_d;
  logic [XLEN/8-1:0]   be_q;
  logic [XLEN-1:0]     adr_in;
  logic [XLEN/8-1:0]   be_in;
  logic                cnt_clear, cnt_en, expired;

  assign start  = ValidInstruction_M & MemEn_M & ~Flush_M;
  assign adr_in = ComputeResult_M & ADR_MASK;
  assign be_in  = MemWriteEn_M ? MemWriteByteEn_M : '1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MEM_IDLE;
      discard_q <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      rdata_q   <= rdata_d;
      if (state_q == MEM_IDLE && start) begin
        we_q    <= MemWriteEn_M;
        adr_q   <= adr_in;
        wdata_q <= MemWriteData_M;
        be_q    <= be_in;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      MEM_IDLE: begin
        discard_d = 1'b0;
        if (start) state_d = DBusGnt ? MEM_RESP : MEM_REQ;
      end
      MEM_REQ: begin
        if (DBusGnt) begin
          state_d   = MEM_RESP;
          discard_d = Flush_M;
        end else if (Flush_M) begin
          state_d = MEM_IDLE;
        end
      end
      MEM_RESP: begin
        if (Flush_M) discard_d = 1'b1;
        if (DBusRValid) begin
          state_d   = (!DBusErr && !discard_q && StallExt_W) ? MEM_HOLD : MEM_IDLE;
          discard_d = 1'b0;
        end else if (expired) begin
          state_d   = MEM_IDLE;
          discard_d = 1'b0;
        end
      end
      MEM_HOLD: begin
        if (!StallExt_W) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign cnt_clear = (state_q != MEM_RESP) && (state_d == MEM_RESP);
  assign cnt_en    = (state_q == MEM_RESP) && !DBusRValid;

  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  // Completion data bypasses rdata_q so the pipeline can advance in the RValid cycle.
  always_comb begin
    DBusReq        = 1'b0;
    DBusWe         = we_q;
    DBusAdr        = adr_q;
    DBusWData      = wdata_q;
    DBusByteEn     = be_q;
    MemReadData_M  = rdata_q;
    MemDataValid_M = 1'b0;
    AccessFault_M  = 1'b0;
    Stall_M        = 1'b0;
    rdata_d        = rdata_q;
    unique case (state_q)
      MEM_IDLE: begin
        DBusReq    = start;
        DBusWe     = MemWriteEn_M;
        DBusAdr    = adr_in;
        DBusWData  = MemWriteData_M;
        DBusByteEn = be_in;
        Stall_M    = start;
      end
      MEM_REQ: begin
        DBusReq = 1'b1;
        Stall_M = 1'b1;
      end
      MEM_RESP: begin
        Stall_M = ~(DBusRValid & ~StallExt_W);
        if (DBusRValid && !discard_q) begin
          if (DBusErr) begin
            AccessFault_M = 1'b1;
            rdata_d       = '0;
          end else begin
            MemDataValid_M = 1'b1;
            rdata_d        = we_q ? '0 : DBusRData;
          end
          MemReadData_M = rdata_d;
        end else if (!DBusRValid && expired && !discard_q) begin
          AccessFault_M = 1'b1;
        end
      end
      MEM_HOLD: begin
        MemDataValid_M = 1'b1;
        Stall_M        = StallExt_W;
      end
      default: ;
    endcase
    if (!reset) begin
      DBusReq        = 1'b0;
      DBusWe         = 1'b0;
      DBusAdr        = '0;
      DBusWData      = '0;
      DBusByteEn     = '0;
      MemReadData_M  = '0;
      MemDataValid_M = 1'b0;
      AccessFault_M  = 1'b0;
      Stall_M        = 1'b0;
    end
  end

endmodule
